uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tx.sv | 29 ++
 rtl/uart_transmitter.sv | 168 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmitter types and line constants.
package uart_pkg;

    localparam int LEN_FIELD_W = 4;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LEN,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_baud_tx.sv
// Free-running bit-period tick: one tx_clk wide, every CLK_PER_BIT cycles.
module uart_baud_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 10
) (
    input  logic tx_clk,
    input  logic rst_n,
    output logic baudratetx
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign baudratetx = (cnt == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// Framed UART transmitter: length field, start, data LSB first, stop.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int CLK_PER_BIT = 10
) (
    input  logic                   tx_clk,
    input  logic                   rst_n,
    input  logic                   tx_start,
    input  logic [DATA_LENGTH-1:0] parallel_datain,
    input  logic                   parity_type,
    output logic                   serialdata_out,
    output logic                   tx_done,
    output logic                   baudratetx
);

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    localparam logic [LEN_FIELD_W-1:0] LEN_VAL =
        LEN_FIELD_W'(DATA_LENGTH + P + 2);
    localparam logic [3:0] LAST_BIT = 4'(DATA_LENGTH - 1);

    tx_state_e              state;
    tx_state_e              state_nxt;
    logic [3:0]             bit_cnt;
    logic [3:0]             bit_cnt_nxt;
    logic [DATA_LENGTH-1:0] data_r;
    logic [DATA_LENGTH-1:0] data_nxt;
    logic [DATA_LENGTH-1:0] data_nb;
    logic [1:0]             len_idx;
    logic                   sout_nxt;
    logic                   tick;

`ifdef UART_TX_PARITY_EN
    logic par_bit;
    logic par_bit_nxt;
`else
    logic unused_parity;
    assign unused_parity = parity_type;
`endif

    uart_baud_tx #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_baud (
        .tx_clk    (tx_clk),
        .rst_n     (rst_n),
        .baudratetx(tick)
    );

    assign baudratetx = tick;
    assign tx_done    = (state == IDLE);
    assign len_idx    = bit_cnt[1:0] - 2'd1;
    assign data_nb    = data_r >> (bit_cnt + 4'd1);

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            data_r         <= '0;
            serialdata_out <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_bit        <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            bit_cnt        <= bit_cnt_nxt;
            data_r         <= data_nxt;
            serialdata_out <= sout_nxt;
`ifdef UART_TX_PARITY_EN
            par_bit        <= par_bit_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (tx_start) state_nxt = WAIT;
            WAIT:  if (tick) state_nxt = LEN;
            LEN:   if (tick && bit_cnt == 4'd0) state_nxt = START;
            START: if (tick) state_nxt = DATA;
            DATA: begin
                if (tick && bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) state_nxt = STOP;
`endif
            STOP:  if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next line level is chosen on each tick; the line itself is registered.
    always_comb begin
        bit_cnt_nxt = bit_cnt;
        data_nxt    = data_r;
        sout_nxt    = serialdata_out;
`ifdef UART_TX_PARITY_EN
        par_bit_nxt = par_bit;
`endif
        unique case (state)
            IDLE: begin
                sout_nxt = IDLE_LEVEL;
                if (tx_start) begin
                    data_nxt    = parallel_datain;
                    bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                    par_bit_nxt = ^parallel_datain ^ parity_type;
`endif
                end
            end
            WAIT: begin
                if (tick) begin
                    sout_nxt    = LEN_VAL[LEN_FIELD_W-1];
                    bit_cnt_nxt = 4'(LEN_FIELD_W - 1);
                end
            end
            LEN: begin
                if (tick) begin
                    if (bit_cnt == 4'd0) begin
                        sout_nxt = START_LEVEL;
                    end else begin
                        sout_nxt    = LEN_VAL[len_idx];
                        bit_cnt_nxt = bit_cnt - 4'd1;
                    end
                end
            end
            START: begin
                if (tick) begin
                    sout_nxt    = data_r[0];
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        sout_nxt = par_bit;
`else
                        sout_nxt = STOP_LEVEL;
`endif
                    end else begin
                        sout_nxt    = data_nb[0];
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) sout_nxt = STOP_LEVEL;
`endif
            STOP: if (tick) sout_nxt = IDLE_LEVEL;
            default: sout_nxt = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: random and directed frames,
// mid-frame restart attempts, async reset abort and back-to-back sends.
module tb_uart_transmitter;

    localparam int DL  = 8;
    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 4 + 1 + DL + P + 1;

    logic          tx_clk = 1'b0;
    logic          rst_n;
    logic          tx_start;
    logic [DL-1:0] parallel_datain;
    logic          parity_type;
    logic          serialdata_out;
    logic          tx_done;
    logic          baudratetx;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];

    uart_transmitter #(
        .DATA_LENGTH(DL),
        .CLK_PER_BIT(CPB)
    ) dut (
        .tx_clk         (tx_clk),
        .rst_n          (rst_n),
        .tx_start       (tx_start),
        .parallel_datain(parallel_datain),
        .parity_type    (parity_type),
        .serialdata_out (serialdata_out),
        .tx_done        (tx_done),
        .baudratetx     (baudratetx)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transmitted bit sequence, bit i = i-th bit on the line.
    function automatic logic [31:0] model(input logic [DL-1:0] d,
                                          input logic pt);
        logic [31:0] f;
        int k;
        int len;
        f = '0;
        k = 0;
        len = DL + P + 2;
        for (int i = 3; i >= 0; i--) begin
            f[k] = 1'((len >> i) & 1);
            k++;
        end
        f[k] = 1'b0;
        k++;
        for (int i = 0; i < DL; i++) begin
            f[k] = d[i];
            k++;
        end
        if (P == 1) begin
            f[k] = 1'(($countones(d) + int'(pt)) % 2);
            k++;
        end
        f[k] = 1'b1;
        return f;
    endfunction

    // Acceptance watcher: a request seen while idle becomes a frame.
    initial begin
        forever begin
            @(negedge tx_clk);
            if (rst_n === 1'b1 && tx_start && tx_done)
                exp_q.push_back(model(parallel_datain, parity_type));
        end
    end

    int          m_j;
    bit          m_abort;
    bit          m_done_ok;
    logic [31:0] m_got;
    logic [31:0] m_exp;

    // Monitor: captures each frame mid-bit and checks its length.
    initial begin
        forever begin
            @(negedge tx_clk);
            if (rst_n === 1'b1 && tx_done === 1'b0) begin
                m_j = 0;
                while (rst_n && !baudratetx && m_j <= CPB) begin
                    @(negedge tx_clk);
                    m_j++;
                end
                m_abort   = !rst_n;
                m_got     = '0;
                m_done_ok = 1'b1;
                if (!m_abort && !baudratetx) begin
                    chk("first_tick_timeout", 32'd1, 32'd0);
                    m_abort = 1'b1;
                end
                for (m_j = 1; m_j <= NB * CPB + 1 && !m_abort; m_j++) begin
                    @(negedge tx_clk);
                    if (!rst_n) begin
                        m_abort = 1'b1;
                    end else begin
                        if (((m_j - 1) % CPB) == CPB / 2)
                            m_got[(m_j - 1) / CPB] = serialdata_out;
                        if (tx_done !== (m_j == NB * CPB + 1))
                            m_done_ok = 1'b0;
                    end
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    m_exp = exp_q.pop_front();
                    if (!m_abort) begin
                        chk("frame_bits", m_got, m_exp);
                        chk("frame_duration", 32'(m_done_ok), 32'd1);
                    end
                end
            end
        end
    end

    task automatic send(input logic [DL-1:0] d, input logic pt);
        @(posedge tx_clk);
        #1;
        tx_start        = 1'b1;
        parallel_datain = d;
        parity_type     = pt;
        @(posedge tx_clk);
        #1;
        tx_start = 1'b0;
        @(negedge tx_clk);
        chk("accept_done_low", 32'(tx_done), 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge tx_clk);
        while ((exp_q.size() != 0 || !tx_done) && n < 3 * NB * CPB) begin
            @(negedge tx_clk);
            n++;
        end
        chk("idle_timeout", 32'(n >= 3 * NB * CPB), 32'd0);
        repeat (2) @(negedge tx_clk);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (!baudratetx && n <= CPB) begin
            @(negedge tx_clk);
            n++;
        end
        chk("tick_timeout", 32'(baudratetx), 32'd1);
    endtask

    int hi;
    int gap;

    initial begin
        rst_n           = 1'b0;
        tx_start        = 1'b0;
        parallel_datain = '0;
        parity_type     = 1'b0;
        repeat (3) @(negedge tx_clk);
        chk("rst_line", 32'(serialdata_out), 32'd1);
        chk("rst_done", 32'(tx_done), 32'd1);
        chk("rst_baud", 32'(baudratetx), 32'd0);
        #2 rst_n = 1'b1;

        @(negedge tx_clk);
        wait_tick();
        @(negedge tx_clk);
        chk("tick_width", 32'(baudratetx), 32'd0);
        gap = 1;
        while (!baudratetx && gap < 3 * CPB) begin
            @(negedge tx_clk);
            gap++;
        end
        chk("tick_period", 32'(gap), 32'(CPB));

        send(8'hA5, 1'b0);
        wait_idle();
        send(8'h07, 1'b1);
        wait_idle();
        send(8'h07, 1'b0);
        wait_idle();
        send(8'h3C, 1'b0);
        wait_idle();

        send(8'h3C, 1'b1);
        repeat (40) @(posedge tx_clk);
        #1;
        tx_start        = 1'b1;
        parallel_datain = 8'hFF;
        parity_type     = 1'b0;
        @(posedge tx_clk);
        #1;
        tx_start = 1'b0;
        wait_idle();

        send(8'h0F, 1'b0);
        wait_tick();
        repeat (1 + 9 * CPB + CPB / 2) @(negedge tx_clk);
        chk("pre_rst_data4", 32'(serialdata_out), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_line", 32'(serialdata_out), 32'd1);
        chk("async_rst_done", 32'(tx_done), 32'd1);
        chk("async_rst_baud", 32'(baudratetx), 32'd0);
        repeat (3) @(negedge tx_clk);
        #2 rst_n = 1'b1;
        chk("rst_flush_q", 32'(exp_q.size()), 32'd0);
        hi = 0;
        repeat (3 * CPB) begin
            @(negedge tx_clk);
            if (!serialdata_out || !tx_done) hi++;
        end
        chk("no_resume", 32'(hi), 32'd0);

        send(8'h3C, 1'b1);
        wait_idle();

        @(posedge tx_clk);
        #1;
        tx_start        = 1'b1;
        parallel_datain = 8'h55;
        parity_type     = 1'($urandom_range(0, 1));
        gap = 0;
        do begin
            @(negedge tx_clk);
            gap++;
        end while (tx_done && gap < 5);
        gap = 0;
        while (!tx_done && gap < NB * CPB + 2 * CPB) begin
            @(negedge tx_clk);
            gap++;
        end
        hi = 1;
        @(negedge tx_clk);
        while (tx_done && hi < 10) begin
            hi++;
            @(negedge tx_clk);
        end
        chk("b2b_done_width", 32'(hi), 32'd1);
        @(posedge tx_clk);
        #1;
        tx_start = 1'b0;
        wait_idle();

        for (int r = 0; r < 10; r++) begin
            send(DL'($urandom), 1'($urandom_range(0, 1)));
            wait_idle();
            repeat ($urandom_range(0, 25)) @(negedge tx_clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
